// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder one-hot select decoder.
// Holds the FSM state encoding, blanking gap length and the one-hot decode function.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MANUAL,
    ST_SCAN,
    ST_BLANK
  } state_t;

  localparam int BLANK_CYCLES = 2;
  localparam int MAX_OUT      = 256;

  // Returns a MAX_OUT-wide vector; callers keep the low N_OUT bits.
  function automatic logic [MAX_OUT-1:0] onehot_dec(input int unsigned sel, input int unsigned n);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (sel < n) v[sel[7:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// Loadable down-counter that times how long each scan channel stays active.
// o_done is high while the count sits at zero (final cycle of the channel).
module scan_decoder_dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic [DWELL_W-1:0] o_count,
  output logic               o_done
);

  logic [DWELL_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select decoder with manual decode and timed auto-scan modes.
// Define SCAN_DECODER_BLANK_EN to insert a BLANK_CYCLES all-zero gap between scan channels.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N_OUT   = 8,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   dout,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               valid,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_idx;
  logic [N_OUT-1:0]   r_dout;
  logic [SEL_W-1:0]   r_cur_sel;
  logic               r_valid;
  logic               r_wrap;
`ifdef SCAN_DECODER_BLANK_EN
  logic [1:0]         r_blank;
`endif

  logic [DWELL_W-1:0] w_cnt;
  logic               w_done;
  logic               w_start;
  logic [SEL_W-1:0]   w_start_idx;
  logic [SEL_W-1:0]   w_next_idx;
  logic               w_sel_ok;
  logic               w_cnt_load;
  logic [DWELL_W-1:0] w_cnt_val;
  logic               w_cnt_dec;

  // w_start marks an edge that begins a fresh channel and reloads the dwell counter.
  always_comb begin
    w_next_idx  = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    w_sel_ok    = ({1'b0, sel_in} < (SEL_W + 1)'(N_OUT));
    w_start     = 1'b0;
    w_start_idx = '0;
    if (en && mode) begin
      if ((r_state == ST_IDLE) || (r_state == ST_MANUAL)) begin
        w_start = 1'b1;
`ifdef SCAN_DECODER_BLANK_EN
      end else if ((r_state == ST_BLANK) && (r_blank == '0)) begin
        w_start     = 1'b1;
        w_start_idx = r_idx;
`else
      end else if ((r_state == ST_SCAN) && w_done) begin
        w_start     = 1'b1;
        w_start_idx = w_next_idx;
`endif
      end
    end
    w_cnt_load = !en || w_start;
    w_cnt_val  = w_start ? dwell : '0;
    w_cnt_dec  = en && mode && (r_state == ST_SCAN);
  end

  scan_decoder_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_dout    <= '0;
      r_cur_sel <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
      r_blank   <= '0;
`endif
    end else if (!en) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_dout    <= '0;
      r_cur_sel <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (!mode) begin
      r_state   <= ST_MANUAL;
      r_idx     <= '0;
      r_dout    <= N_OUT'(onehot_dec(32'(sel_in), N_OUT));
      r_cur_sel <= w_sel_ok ? sel_in : '0;
      r_valid   <= w_sel_ok;
      r_wrap    <= 1'b0;
    end else if (w_start) begin
      r_state   <= ST_SCAN;
      r_idx     <= w_start_idx;
      r_dout    <= N_OUT'(onehot_dec(32'(w_start_idx), N_OUT));
      r_cur_sel <= w_start_idx;
      r_valid   <= 1'b1;
      r_wrap    <= (w_start_idx == LAST_IDX) && (dwell == '0);
    end else if (r_state == ST_SCAN) begin
`ifdef SCAN_DECODER_BLANK_EN
      if (w_done) begin
        r_state   <= ST_BLANK;
        r_idx     <= w_next_idx;
        r_dout    <= '0;
        r_cur_sel <= '0;
        r_valid   <= 1'b0;
        r_wrap    <= 1'b0;
        r_blank   <= 2'(BLANK_CYCLES - 1);
      end else
`endif
      // Wrap is raised for the cycle in which the last channel's count reaches zero.
      r_wrap <= (r_idx == LAST_IDX) && (w_cnt == DWELL_W'(1));
`ifdef SCAN_DECODER_BLANK_EN
    end else if (r_state == ST_BLANK) begin
      r_blank <= r_blank - 1'b1;
`endif
    end
  end

  assign dout    = r_dout;
  assign cur_sel = r_cur_sel;
  assign valid   = r_valid;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: manual decode, out-of-range select, scan timing,
// dwell changes, en/rst/mode disruption, and blanking gaps when SCAN_DECODER_BLANK_EN is set.
module tb_scan_decoder;

  localparam int N  = 8;
  localparam int SW = 3;
  localparam int DW = 16;
`ifdef SCAN_DECODER_BLANK_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  typedef struct packed {
    logic [7:0] dout;
    logic [2:0] cs;
    logic       valid;
    logic       wrap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [SW-1:0] selIn;
  logic [DW-1:0] dwell;
  logic [N-1:0]  dout;
  logic [SW-1:0] curSel;
  logic          valid;
  logic          wrap;

  logic          en6;
  logic          mode6;
  logic [2:0]    sel6;
  logic [5:0]    dout6;
  logic [2:0]    curSel6;
  logic          valid6;
  logic          wrap6;

  exp_t expQ[$];
  exp_t expQ6[$];
  int   nTests = 0;
  int   nFail  = 0;

`ifdef SCAN_DECODER_BLANK_EN
  int tDw[11] = '{0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0};
  int tCh[11] = '{0, -1, -1, 1, 1, 1, 1, -1, -1, 2, -1};
`else
  int tDw[11] = '{0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  int tCh[11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
`endif

  always #5 clk = ~clk;

  scan_decoder #(.N_OUT(N), .SEL_W(SW), .DWELL_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .sel_in  (selIn),
    .dwell   (dwell),
    .dout    (dout),
    .cur_sel (curSel),
    .valid   (valid),
    .wrap    (wrap)
  );

  scan_decoder #(.N_OUT(6), .SEL_W(3), .DWELL_W(DW)) dutNarrow (
    .clk     (clk),
    .rst     (rst),
    .en      (en6),
    .mode    (mode6),
    .sel_in  (sel6),
    .dwell   (dwell),
    .dout    (dout6),
    .cur_sel (curSel6),
    .valid   (valid6),
    .wrap    (wrap6)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nTests++;
    if (got !== want) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t chExp(input int ch, input bit w);
    exp_t e;
    e = '0;
    if (ch >= 0) begin
      e.dout  = 8'(1) << ch;
      e.cs    = 3'(ch);
      e.valid = 1'b1;
      e.wrap  = w;
    end
    return e;
  endfunction

  task automatic applyStimulus(input string tag, input logic r, input logic e, input logic m,
                               input logic [2:0] s, input logic [15:0] d, input exp_t ex);
    exp_t want;
    rst   = r;
    en    = e;
    mode  = m;
    selIn = s;
    dwell = d;
    expQ.push_back(ex);
    @(posedge clk);
    #1;
    want = expQ.pop_front();
    checkOutput(tag, {19'b0, wrap, valid, curSel, dout},
                {19'b0, want.wrap, want.valid, want.cs, want.dout});
  endtask

  task automatic applyStimulusNarrow(input logic [2:0] s, input logic [5:0] wDout,
                                     input logic [2:0] wCs, input logic wValid);
    exp_t want;
    en6  = 1'b1;
    sel6 = s;
    expQ6.push_back('{dout: {2'b0, wDout}, cs: wCs, valid: wValid, wrap: 1'b0});
    @(posedge clk);
    #1;
    want = expQ6.pop_front();
    checkOutput("narrow", {19'b0, wrap6, valid6, curSel6, 2'b0, dout6},
                {19'b0, want.wrap, want.valid, want.cs, want.dout});
  endtask

  // Expected scan stream for a constant dwell, starting from a non-scan state.
  task automatic runScan(input string tag, input int dw, input int cycles);
    int per;
    per = dw + 1 + GAP;
    for (int k = 0; k < cycles; k++) begin
      int pos, ch, off;
      pos = k % (per * N);
      ch  = pos / per;
      off = pos % per;
      applyStimulus(tag, 1'b0, 1'b1, 1'b1, 3'd0, 16'(dw),
                    (off <= dw) ? chExp(ch, (ch == N - 1) && (off == dw)) : chExp(-1, 1'b0));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; selIn = '0; dwell = '0;
    en6 = 1'b0; mode6 = 1'b0; sel6 = '0;

    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 3'd0, 16'd0, chExp(-1, 1'b0));
    applyStimulus("rst_prio", 1'b1, 1'b1, 1'b1, 3'd3, 16'd0, chExp(-1, 1'b0));

    for (int s = 0; s < N; s++)
      applyStimulus("manual", 1'b0, 1'b1, 1'b0, 3'(s), 16'd0, chExp(s, 1'b0));

    applyStimulusNarrow(3'd6, 6'h00, 3'd0, 1'b0);
    applyStimulusNarrow(3'd7, 6'h00, 3'd0, 1'b0);
    applyStimulusNarrow(3'd5, 6'h20, 3'd5, 1'b1);
    applyStimulusNarrow(3'd0, 6'h01, 3'd0, 1'b1);

    runScan("scan_d2", 2, 2 * N * (3 + GAP));
    applyStimulus("scan2man", 1'b0, 1'b1, 1'b0, 3'd2, 16'd2, chExp(2, 1'b0));

    runScan("scan_d0", 0, 2 * N * (1 + GAP));
    applyStimulus("scan2man", 1'b0, 1'b1, 1'b0, 3'd2, 16'd0, chExp(2, 1'b0));

    for (int k = 0; k < 11; k++)
      applyStimulus("dwell_chg", 1'b0, 1'b1, 1'b1, 3'd0, 16'(tDw[k]),
                    chExp(tCh[k], tCh[k] == N - 1));
    applyStimulus("scan2man", 1'b0, 1'b1, 1'b0, 3'd2, 16'd0, chExp(2, 1'b0));

    runScan("pre_en", 2, 5 * (3 + GAP) + 1);
    applyStimulus("en_off", 1'b0, 1'b0, 1'b1, 3'd0, 16'd2, chExp(-1, 1'b0));
    runScan("re_en", 2, 6);
    applyStimulus("scan2man", 1'b0, 1'b1, 1'b0, 3'd2, 16'd2, chExp(2, 1'b0));

    runScan("pre_rst", 2, 5 * (3 + GAP) + 1);
    applyStimulus("rst_mid", 1'b1, 1'b1, 1'b1, 3'd0, 16'd2, chExp(-1, 1'b0));
    runScan("post_rst", 2, 6);
    applyStimulus("scan2man", 1'b0, 1'b1, 1'b0, 3'd2, 16'd0, chExp(2, 1'b0));

    runScan("pre_wrap", 0, 6 * (1 + GAP) + 1);
    applyStimulus("wrap_supp", 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, chExp(-1, 1'b0));
    applyStimulus("idle_hold", 1'b0, 1'b0, 1'b0, 3'd1, 16'd0, chExp(-1, 1'b0));
    applyStimulus("idle2man", 1'b0, 1'b1, 1'b0, 3'd6, 16'd0, chExp(6, 1'b0));

    runScan("scan_d1", 1, 2 * N * (2 + GAP));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised, registered one-hot select decoder for display row/digit/bank multiplexing. Supports two modes:
- Manual: decodes an external select.
- Scan: cycles through all outputs with a programmable per-channel dwell time and flags each full scan.
It sits between the display timing controller and the row/bank drivers of the video display processor.

Parameters:
N_OUT, 8, number of one-hot outputs; legal range 2..256.
SEL_W, 3, select width; must satisfy N_OUT <= 2**SEL_W.
DWELL_W, 16, width of the dwell count input.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  block enable; low forces outputs inactive.
mode  input  1  0 = manual decode, 1 = auto scan.
sel_in  input  SEL_W  manual-mode select.
dwell  input  DWELL_W  scan mode: channel active for dwell+1 cycles.
dout  output  N_OUT  registered one-hot (or all-zero) select outputs.
cur_sel  output  SEL_W  index of the active channel; 0 when none active.
valid  output  1  high when exactly one dout bit is high.
wrap  output  1  one-cycle pulse on the last active cycle of channel N_OUT-1 in scan mode.

Behaviour:
- Reset (rst=1 at a clk edge): dout=0, cur_sel=0, valid=0, wrap=0, state IDLE, scan index 0, dwell counter 0. rst has priority over all other inputs.
- States: IDLE, MANUAL, SCAN (plus BLANK when the optional feature is enabled).
- IDLE:
  - en=0 -> stay in IDLE; outputs zero, scan index held at 0.
  - en=1 and mode=0 -> MANUAL.
  - en=1 and mode=1 -> SCAN at index 0.
- MANUAL:
  - Each cycle, dout <= onehot(sel_in). Latency is 1 cycle from sel_in to dout.
  - If sel_in >= N_OUT: dout=0, valid=0, cur_sel=0.
- SCAN:
  - Channel i drives dout[i]. dwell is sampled on the first cycle of each channel; the channel stays active for dwell+1 cycles. dwell=0 gives 1 cycle per channel.
  - At the end of a channel, the index advances by 1, wrapping from N_OUT-1 to 0.
  - wrap is high for exactly the final active cycle of channel N_OUT-1.
- Mode change while en=1: takes effect at the next edge.
  - Manual -> scan: always restarts at index 0 with a fresh dwell.
  - Scan -> manual: decodes sel_in immediately; no wrap pulse.
- en deassert in any state: next edge -> IDLE, dout=0, scan index cleared, any pending wrap suppressed.
- Reset mid-scan: same as a power-on reset; on the next en=1 scan the sequence restarts at index 0.
- Invariant: dout has at most one bit set in every cycle. valid equals |dout.
- Dwell counter width is DWELL_W with no overflow; maximum dwell = 2**DWELL_W cycles per channel.

Optional Feature:
- Macro: SCAN_DECODER_BLANK_EN.
- Defined: between consecutive scan channels (including wrap N_OUT-1 -> 0), a BLANK state holds dout=0, valid=0 for exactly 2 cycles, giving anti-ghosting gaps for row drivers.
  - wrap pulses on the last active cycle of channel N_OUT-1, not during BLANK.
  - Manual mode is unaffected.
  - en=0 or rst during BLANK -> IDLE.
- Undefined: no BLANK state; the next channel follows immediately in the following cycle.

Decomposition:
- Shared package scan_decoder_pkg holds:
  - the state encoding type (IDLE, MANUAL, SCAN, BLANK);
  - the constant BLANK_CYCLES=2;
  - a function onehot_dec(sel, n) returning the N_OUT-bit one-hot vector, or zero when sel >= n.
- One sub-module is natural: dwell_counter (loadable down-counter, DWELL_W bits, outputs a done flag). The FSM and output registers stay in scan_decoder.

Test Plan:
1. Manual decode: rst 1 cycle, en=1, mode=0, sel_in sweeps 0..7 -> dout = 8'h01, 02, 04 ... 80, each one cycle after the corresponding sel_in; valid=1; cur_sel matches.
2. Out-of-range select: N_OUT=6, SEL_W=3, sel_in=6 then 7 -> dout=0, valid=0, cur_sel=0; sel_in=5 -> dout=6'h20.
3. Scan timing: mode=1, dwell=2 -> each dout bit high for 3 cycles in order 0..7; wrap high only on cycle 24 after scan start; sequence repeats; wrap recurs every 24 cycles.
4. Dwell=0 and mid-scan dwell change: dwell=0 gives 1 cycle per channel and wrap every 8 cycles. Changing dwell from 0 to 3 mid-channel takes effect only at the next channel start.
5. Disruption: during scan at channel 5, deassert en for 1 cycle -> dout=0 next cycle. Re-enable -> restart at channel 0. Repeat with rst asserted instead -> same result. Toggle mode to 0 with sel_in=2 -> dout=8'h04 next cycle, no wrap.
6. With SCAN_DECODER_BLANK_EN, dwell=1 -> pattern per channel is 2 cycles one-hot then 2 cycles zero; wrap every 32 cycles. Run the same stimulus without the macro -> wrap every 16 cycles, no zero gaps.
